// File: rtl/hazard_detect_pkg.sv
// Shared pipeline definitions for the hazard detection unit: FSM state
// encoding, bubble counter width and the register-match helper.
package hazard_detect_pkg;

    localparam int unsigned STATE_W = 1;
    localparam logic [STATE_W-1:0] STATE_RUN    = 1'b0;
    localparam logic [STATE_W-1:0] STATE_BSTALL = 1'b1;

    localparam int unsigned BUBBLE_CNT_W = 16;
    localparam logic [BUBBLE_CNT_W-1:0] BUBBLE_ONE = 'd1;
    localparam logic [BUBBLE_CNT_W-1:0] BUBBLE_MAX = '1;

    // EX destination matches an ID source; register 0 is hardwired and never conflicts.
    function automatic logic reg_match(input logic [4:0] wreg,
                                       input logic [4:0] rs,
                                       input logic [4:0] rt,
                                       input logic       uses_rt);
        return (wreg != 5'd0) && ((wreg == rs) || (uses_rt && (wreg == rt)));
    endfunction

endpackage

// File: rtl/hazard_compare.sv
// Register match and hazard classification between the ID instruction
// and the instruction currently in EX. Purely combinational.
module hazard_compare
    import hazard_detect_pkg::*;
(
    input  logic [4:0] IFID_Rs,
    input  logic [4:0] IFID_Rt,
    input  logic       IFID_UsesRt,
    input  logic       IFID_Branch,
    input  logic       IDEX_MemRead,
    input  logic       IDEX_RegWrite,
    input  logic [4:0] IDEX_WriteReg,
    output logic       load_use,
    output logic       branch_alu,
    output logic       branch_load
);

    logic match;

    // Classify the dependency: loads need a bubble before any consumer,
    // branches resolve in ID so they also wait on ALU results.
    always_comb begin
        match       = reg_match(IDEX_WriteReg, IFID_Rs, IFID_Rt, IFID_UsesRt);
        load_use    = IDEX_MemRead & match & ~IFID_Branch;
        branch_alu  = IFID_Branch & IDEX_RegWrite & ~IDEX_MemRead & match;
        branch_load = IFID_Branch & IDEX_MemRead & match;
    end

endmodule

// File: rtl/hazard_detect.sv
// Pipeline hazard detection: stall/flush control for IF/ID and a
// saturating count of inserted bubbles.
//
// state  | meaning
// -------+--------------------------------------------------------------
// RUN    | normal issue; stalls are decided from the current hazard terms
// BSTALL | second bubble of a branch-after-load; stall unconditionally
module hazard_detect
    import hazard_detect_pkg::*;
(
    input  logic                    Clk,
    input  logic                    Rst_n,
    input  logic [4:0]              IFID_Rs,
    input  logic [4:0]              IFID_Rt,
    input  logic                    IFID_UsesRt,
    input  logic                    IFID_Branch,
    input  logic                    IFID_Jump,
    input  logic                    BranchTaken,
    input  logic                    IDEX_MemRead,
    input  logic                    IDEX_RegWrite,
    input  logic [4:0]              IDEX_WriteReg,
    output logic                    DangerSel,
    output logic                    PCWrite,
    output logic                    IFIDWrite,
    output logic                    IFIDFlush,
    output logic [BUBBLE_CNT_W-1:0] BubbleCnt
);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_nxt;
    logic               load_use;
    logic               branch_alu;
    logic               branch_load;
    logic               stall;

    hazard_compare u_compare (
        .IFID_Rs       (IFID_Rs),
        .IFID_Rt       (IFID_Rt),
        .IFID_UsesRt   (IFID_UsesRt),
        .IFID_Branch   (IFID_Branch),
        .IDEX_MemRead  (IDEX_MemRead),
        .IDEX_RegWrite (IDEX_RegWrite),
        .IDEX_WriteReg (IDEX_WriteReg),
        .load_use      (load_use),
        .branch_alu    (branch_alu),
        .branch_load   (branch_load)
    );

    // Zero-latency stall/flush decode; reset forces a held pipeline with no flush.
    always_comb begin
        state_nxt = STATE_RUN;
        stall     = 1'b0;
        if (!Rst_n) begin
            stall = 1'b1;
        end else if (state == STATE_BSTALL) begin
            stall = 1'b1;
        end else begin
            stall = load_use | branch_alu | branch_load;
            if (branch_load) begin
                state_nxt = STATE_BSTALL;
            end
        end
        DangerSel = stall;
        PCWrite   = ~stall;
        IFIDWrite = ~stall;
        IFIDFlush = Rst_n & ~stall & (IFID_Jump | (IFID_Branch & BranchTaken));
    end

    // State register; reset drops any pending second bubble.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= STATE_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Count bubble cycles, holding at all-ones rather than wrapping.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            BubbleCnt <= '0;
        end else if (DangerSel && (BubbleCnt != BUBBLE_MAX)) begin
            BubbleCnt <= BubbleCnt + BUBBLE_ONE;
        end
    end

endmodule

// File: doc/hazard_detect.md
HAZARD_DETECT -- requirements
Module: hazard_detect

Interface
REQ-001 The block SHALL have the port Clk, input, 1 bit: the single pipeline clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port Rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 The block SHALL have the ports IFID_Rs and IFID_Rt, input, 5 bits each: source registers of the instruction in ID.
REQ-004 The block SHALL have the port IFID_UsesRt, input, 1 bit: ID instruction reads Rt (R-type, store, branch).
REQ-005 The block SHALL have the ports IFID_Branch and IFID_Jump, input, 1 bit each: ID instruction is a branch or a jump.
REQ-006 The block SHALL have the port BranchTaken, input, 1 bit: ID branch comparator result, valid when IFID_Branch=1.
REQ-007 The block SHALL have the ports IDEX_MemRead and IDEX_RegWrite, input, 1 bit each: EX-stage load and register-write flags.
REQ-008 The block SHALL have the port IDEX_WriteReg, input, 5 bits: EX-stage destination register after RegDst selection.
REQ-009 The block SHALL have the port DangerSel, output, 1 bit: 1 zeroes ID/EX control signals (bubble).
REQ-010 The block SHALL have the ports PCWrite and IFIDWrite, output, 1 bit each: 0 holds the PC and the IF/ID register.
REQ-011 The block SHALL have the port IFIDFlush, output, 1 bit: 1 loads a NOP into IF/ID at the next edge.
REQ-012 The block SHALL have the port BubbleCnt, output, 16 bits: count of bubble cycles inserted since reset.

Function
REQ-013 The block SHALL define the match term M = (IDEX_WriteReg != 0) and ((IDEX_WriteReg == IFID_Rs) or (IFID_UsesRt and IDEX_WriteReg == IFID_Rt)); register 0 never creates a hazard.
REQ-014 The block SHALL implement an FSM with states RUN and BSTALL.
REQ-015 In RUN, load-use (IDEX_MemRead and M, IFID_Branch=0) SHALL stall: DangerSel=1, PCWrite=0, IFIDWrite=0 for one cycle; next state RUN.
REQ-016 In RUN, branch-after-ALU (IFID_Branch and IDEX_RegWrite and not IDEX_MemRead and M) SHALL stall for one cycle; next state RUN.
REQ-017 In RUN, branch-after-load (IFID_Branch and IDEX_MemRead and M) SHALL stall this cycle and go to BSTALL.
REQ-018 In BSTALL, the block SHALL stall unconditionally for exactly one cycle, then return to RUN; total branch-after-load penalty is 2 bubbles.
REQ-019 With no stall, DangerSel=0, PCWrite=1, IFIDWrite=1.
REQ-020 IFIDFlush SHALL be 1 only in a non-stall cycle with IFID_Jump=1 or (IFID_Branch=1 and BranchTaken=1); a stall always suppresses the flush in the same cycle.
REQ-021 DangerSel, PCWrite, IFIDWrite and IFIDFlush SHALL be combinational functions of the state and current inputs (zero latency).
REQ-022 BubbleCnt SHALL increment by 1 at each edge where DangerSel=1, and SHALL saturate at 16'hFFFF.
REQ-023 PCWrite SHALL equal IFIDWrite, and both SHALL equal not DangerSel, in every cycle.

Reset
REQ-024 While Rst_n=0, the state SHALL be RUN, BubbleCnt=0, DangerSel=1, PCWrite=0, IFIDWrite=0 and IFIDFlush=0, regardless of the other inputs.
REQ-025 Reset asserted in BSTALL SHALL abort the pending stall; after deassertion, the first edge evaluates from RUN.

Structure
REQ-026 The state encoding (RUN=1'b0, BSTALL=1'b1) and the BubbleCnt width SHALL be placed in the shared pipeline package.
REQ-027 The match and hazard-classification logic SHALL be one sub-module, hazard_compare; the FSM and counter SHALL stay in hazard_detect.

Verification
REQ-028 The bench SHALL cover load-use: IDEX_MemRead=1, IDEX_WriteReg=8, IFID_Rs=8 -> one cycle with DangerSel=1, PCWrite=0; BubbleCnt goes 0->1.
REQ-029 The bench SHALL cover the register-0 exemption: IDEX_MemRead=1, IDEX_WriteReg=0, IFID_Rs=0 -> DangerSel=0, PCWrite=1.
REQ-030 The bench SHALL cover branch-after-load: IFID_Branch=1, IDEX_MemRead=1, IDEX_WriteReg=9, IFID_Rt=9, IFID_UsesRt=1 -> DangerSel=1 for 2 consecutive cycles; BubbleCnt +2.
REQ-031 The bench SHALL cover a taken branch: IFID_Branch=1, BranchTaken=1, no match -> IFIDFlush=1 and DangerSel=0 for that cycle.
REQ-032 The bench SHALL cover a jump during a stall: IFID_Jump=1 coinciding with a load-use match -> IFIDFlush=0 in the stall cycle and 1 in the following cycle.
REQ-033 The bench SHALL cover reset in BSTALL: Rst_n=0 asserted mid-stall -> immediate BubbleCnt=0 and DangerSel=1; after release, no second stall cycle.
